// File: rtl/music_pkg.sv
// Shared note-table constants and loader state encoding.
// Pure declarations; no latency or flow control of its own.
package music_pkg;

    localparam int NOTE_ADDR_W = 7;
    localparam int NOTE_DATA_W = 16;
    localparam int NOTE_DEPTH  = 128;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        HI,
        LO,
        DONE
    } state_t;

    // A length byte of zero encodes a full table.
    function automatic logic [7:0] len_decode(input logic [7:0] len_byte);
        return (len_byte == 8'd0) ? 8'd128 : len_byte;
    endfunction

endpackage

// File: rtl/note_ram_1r1w.sv
// Single-clock note RAM, one write port and one registered read-first read port.
// Read latency 1 cycle; no flow control, no reset so it maps onto block RAM.
module note_ram_1r1w #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/note_table_loader.sv
// Loads the speaker_music note table from a length-prefixed big-endian byte stream.
// Reads return 1 cycle after rd_addr; byte_ready is a registered state decode, so producers hold bytes while it is low.
module note_table_loader
    import music_pkg::*;
#(
    parameter int ADDR_W = NOTE_ADDR_W,
    parameter int DATA_W = NOTE_DATA_W,
    parameter int DEPTH  = NOTE_DEPTH
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              table_valid,
    output logic              load_done,
    output logic [7:0]        words_loaded
);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        word_cnt;
    logic [7:0]        len;
    logic [7:0]        hi_byte;
    logic              accept;
    logic              wr_en;
    logic              rd_primed;
    logic [DATA_W-1:0] ram_q;

    assign accept = byte_valid && byte_ready;
    assign wr_en  = (state == LO) && accept && !load_start;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (load_start) state_nx = LEN;
            LEN: begin
                if (load_start)  state_nx = LEN;
                else if (accept) state_nx = HI;
            end
            HI: begin
                if (load_start)  state_nx = LEN;
                else if (accept) state_nx = LO;
            end
            LO: begin
                if (load_start)  state_nx = LEN;
                else if (accept) state_nx = (word_cnt + 8'd1 == len) ? DONE : HI;
            end
            DONE:    state_nx = load_start ? LEN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            byte_ready   <= 1'b0;
            load_done    <= 1'b0;
            table_valid  <= 1'b0;
            words_loaded <= 8'd0;
            wr_addr      <= '0;
            word_cnt     <= 8'd0;
            len          <= 8'd0;
            hi_byte      <= 8'd0;
            rd_primed    <= 1'b0;
        end else begin
            state      <= state_nx;
            byte_ready <= (state_nx == LEN) || (state_nx == HI) || (state_nx == LO);
            load_done  <= (state_nx == DONE);
            rd_primed  <= 1'b1;

            if (load_start) begin
                wr_addr  <= '0;
                word_cnt <= 8'd0;
            end else if (wr_en) begin
                wr_addr  <= wr_addr + 1'b1;
                word_cnt <= word_cnt + 8'd1;
            end

            if (state == LEN && accept && !load_start) len     <= len_decode(byte_data);
            if (state == HI  && accept && !load_start) hi_byte <= byte_data;

            // A restart issued during the DONE cycle wins over the completion.
            if (load_start)         table_valid <= 1'b0;
            else if (state == DONE) table_valid <= 1'b1;

            if (state == DONE) words_loaded <= len;
        end
    end

    note_ram_1r1w #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (sys_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data ({hi_byte, byte_data}),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // The RAM read register has no reset; mask it until its first post-reset capture.
    assign rd_data = rd_primed ? ram_q : '0;

endmodule

// File: tb/tb_note_table_loader.sv
// Randomized bench for note_table_loader against a byte-position model of the load protocol.
module tb_note_table_loader;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic [6:0]  rd_addr = 7'd0;
    logic [15:0] rd_data;
    logic        table_valid;
    logic        load_done;
    logic [7:0]  words_loaded;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    bit gaps = 1'b0;
    bit rand_rd = 1'b0;
    logic [15:0] wbuf [128];

    // Reference model state, expressed as position within the byte stream.
    logic [15:0] mem_m [128];
    bit          known [128];
    bit          m_loading = 1'b0;
    bit          m_done = 1'b0;
    bit          m_tv = 1'b0;
    logic [7:0]  m_wl = 8'd0;
    logic [7:0]  m_n = 8'd0;
    logic [7:0]  m_hi = 8'd0;
    int          m_cnt = 0;
    logic [15:0] m_rd = 16'd0;
    bit          m_rd_known = 1'b0;

    always #5 sys_clk = ~sys_clk;

    note_table_loader dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .load_start   (load_start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .table_valid  (table_valid),
        .load_done    (load_done),
        .words_loaded (words_loaded)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_loading  = 1'b0;
            m_done     = 1'b0;
            m_tv       = 1'b0;
            m_wl       = 8'd0;
            m_cnt      = 0;
            m_rd       = 16'd0;
            m_rd_known = 1'b1;
        end else begin
            m_rd_known = known[rd_addr];
            m_rd       = mem_m[rd_addr];
            if (m_done) begin
                m_done = 1'b0;
                m_wl   = m_n;
                m_tv   = !load_start;
                if (load_start) begin
                    m_loading = 1'b1;
                    m_cnt     = 0;
                end
            end else if (load_start) begin
                m_loading = 1'b1;
                m_cnt     = 0;
                m_tv      = 1'b0;
            end else if (m_loading && byte_valid) begin
                if (m_cnt == 0) begin
                    m_n = (byte_data == 8'd0) ? 8'd128 : byte_data;
                end else if (m_cnt % 2 == 1) begin
                    m_hi = byte_data;
                end else begin
                    mem_m[m_cnt / 2 - 1] = {m_hi, byte_data};
                    known[m_cnt / 2 - 1] = 1'b1;
                end
                m_cnt++;
                if (m_cnt == 2 * int'(m_n) + 1) begin
                    m_loading = 1'b0;
                    m_done    = 1'b1;
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        if (chk_en) begin
            chk("byte_ready", 32'(byte_ready), 32'(m_loading));
            chk("load_done", 32'(load_done), 32'(m_done));
            chk("table_valid", 32'(table_valid), 32'(m_tv));
            chk("words_loaded", 32'(words_loaded), 32'(m_wl));
            if (m_rd_known) chk("rd_data", 32'(rd_data), 32'(m_rd));
        end
    end

    task automatic start_load();
        @(negedge sys_clk);
        load_start = 1'b1;
        byte_valid = 1'b0;
        @(negedge sys_clk);
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bit done_b;
        bit rdy;
        done_b = 1'b0;
        for (int g = 0; g < 300 && !done_b; g++) begin
            @(negedge sys_clk);
            if (rand_rd) rd_addr = 7'($urandom_range(0, 127));
            if (gaps && $urandom_range(0, 99) < 30) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
            end else begin
                byte_valid = 1'b1;
                byte_data  = b;
                rdy = byte_ready;
                @(posedge sys_clk);
                if (rdy) done_b = 1'b1;
            end
        end
        chk("send_timeout", 32'(done_b), 1);
    endtask

    task automatic idle_bus();
        @(negedge sys_clk);
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input logic [7:0] n_exp, input string tag);
        int g;
        g = 0;
        while (load_done !== 1'b1 && g < 60) begin
            @(negedge sys_clk);
            g++;
        end
        chk({tag, "_done_seen"}, 32'(load_done), 1);
        chk({tag, "_tv_during_done"}, 32'(table_valid), 0);
        @(negedge sys_clk);
        chk({tag, "_single_pulse"}, 32'(load_done), 0);
        chk({tag, "_tv_after"}, 32'(table_valid), 1);
        chk({tag, "_words"}, 32'(words_loaded), 32'(n_exp));
    endtask

    task automatic do_load(input logic [7:0] n, input string tag);
        int cnt;
        cnt = (n == 8'd0) ? 128 : int'(n);
        start_load();
        send(n);
        for (int k = 0; k < cnt; k++) begin
            send(wbuf[k][15:8]);
            send(wbuf[k][7:0]);
        end
        idle_bus();
        wait_done(8'(cnt), tag);
    endtask

    task automatic rd_check(input logic [6:0] a, input logic [15:0] exp, input string tag);
        @(negedge sys_clk);
        rd_addr = a;
        @(negedge sys_clk);
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        logic [7:0] kb;
        logic [7:0] n;
        #2 sys_rst_n = 1'b0;
        #1 chk_en = 1'b1;
        chk("rst_ready", 32'(byte_ready), 0);
        chk("rst_tv", 32'(table_valid), 0);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_rd", 32'(rd_data), 0);
        chk("rst_words", 32'(words_loaded), 0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Basic load, byte_valid held high.
        wbuf[0] = 16'h1234;
        wbuf[1] = 16'hABCD;
        do_load(8'd2, "basic");
        chk("model_w0", 32'(mem_m[0]), 32'h1234);
        chk("model_w1", 32'(mem_m[1]), 32'hABCD);
        rd_check(7'd0, 16'h1234, "basic_rd0");
        rd_check(7'd1, 16'hABCD, "basic_rd1");

        // Same load with producer gaps and a wandering read address.
        wbuf[0] = 16'h1234;
        wbuf[1] = 16'hABCD;
        gaps = 1'b1;
        rand_rd = 1'b1;
        do_load(8'd2, "gaps");
        gaps = 1'b0;
        rand_rd = 1'b0;
        rd_check(7'd0, 16'h1234, "gaps_rd0");
        rd_check(7'd1, 16'hABCD, "gaps_rd1");

        // Full table with N byte zero.
        for (int k = 0; k < 128; k++) begin
            kb = 8'(k);
            wbuf[k] = {kb, ~kb};
        end
        do_load(8'd0, "full");
        @(negedge sys_clk);
        byte_valid = 1'b1;
        byte_data  = 8'h99;
        repeat (3) begin
            @(negedge sys_clk);
            chk("full_no_extra_byte", 32'(byte_ready), 0);
        end
        byte_valid = 1'b0;
        rd_check(7'd127, 16'h7F80, "full_rd127");
        rd_check(7'd5, 16'h05FA, "full_rd5");

        // Abort mid-HI with a byte on offer, then a fresh one-word load.
        start_load();
        chk("abort_tv_cleared", 32'(table_valid), 0);
        send(8'h03);
        send(8'h11);
        send(8'h22);
        @(negedge sys_clk);
        load_start = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h33;
        @(negedge sys_clk);
        load_start = 1'b0;
        byte_valid = 1'b0;
        chk("abort_tv_low", 32'(table_valid), 0);
        send(8'h01);
        send(8'h55);
        send(8'h55);
        idle_bus();
        wait_done(8'd1, "abort");
        rd_check(7'd0, 16'h5555, "abort_rd0");

        // Read-during-write on address 0.
        @(negedge sys_clk);
        rd_addr = 7'd0;
        start_load();
        send(8'h01);
        send(8'hBE);
        send(8'hEF);
        @(negedge sys_clk);
        byte_valid = 1'b0;
        chk("rdw_old", 32'(rd_data), 32'h5555);
        @(negedge sys_clk);
        chk("rdw_new", 32'(rd_data), 32'hBEEF);

        // Asynchronous reset while in LO.
        start_load();
        send(8'h02);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        idle_bus();
        #2 sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(byte_ready), 0);
        chk("mid_rst_tv", 32'(table_valid), 0);
        chk("mid_rst_words", 32'(words_loaded), 0);
        chk("mid_rst_rd", 32'(rd_data), 0);
        chk("mid_rst_done", 32'(load_done), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wbuf[0] = 16'h0102;
        wbuf[1] = 16'h0304;
        do_load(8'd2, "post_rst");
        rd_check(7'd1, 16'h0304, "post_rst_rd1");

        // Randomized loads.
        for (int t = 0; t < 6; t++) begin
            n = 8'($urandom_range(1, 24));
            for (int k = 0; k < int'(n); k++) wbuf[k] = 16'($urandom);
            gaps = 1'b1;
            rand_rd = 1'b1;
            do_load(n, "rand");
            gaps = 1'b0;
            rand_rd = 1'b0;
            rd_check(7'(n - 8'd1), wbuf[n - 8'd1], "rand_last");
        end

        repeat (4) @(negedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/note_table_loader.md
Name: note_table_loader

Overview:
- Writer and responder at the far end of the speaker_music note-table read port, which drives addr[6:0] and consumes data[15:0].
- Holds a 128 x 16 note RAM and serves speaker_music reads with a fixed 1-cycle latency.
- Fills that RAM from a byte stream delivered by the SPI front end, using a valid/ready handshake.
- Tells the player when the table is complete and consistent, so playback never reads a half-loaded table.

Parameters:
- ADDR_W, 7, note-table address width.
- DATA_W, 16, note word width; must be 16 (two bytes per word).
- DEPTH, 128, number of entries; equals 2**ADDR_W.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  single-cycle pulse that begins or restarts a load.
- byte_valid  in  1  stream byte present.
- byte_data  in  8  stream byte.
- byte_ready  out  1  block accepts byte_data this cycle.
- rd_addr  in  ADDR_W  speaker_music read address.
- rd_data  out  DATA_W  registered note word at rd_addr.
- table_valid  out  1  table fully loaded; speaker_music may play.
- load_done  out  1  1-cycle pulse when a load completes.
- words_loaded  out  8  number of words written by the last completed load, 1..128.

Behaviour:
- Reset (asynchronous, sys_rst_n low):
  - state=IDLE, byte_ready=0, table_valid=0, load_done=0, rd_data=0, words_loaded=0.
  - Internal counters are cleared; RAM contents are not reset.
- Byte acceptance: a byte is taken only in a cycle with byte_valid&&byte_ready. byte_ready is a registered function of state: 1 in LEN/HI/LO, 0 in IDLE/DONE.
- State machine:
  - IDLE: on load_start go to LEN; clear table_valid, wr_addr and word count.
  - LEN: the accepted byte is N, the word count. N=0 means 128. Go to HI.
  - HI: the accepted byte is latched as the word's MSB. Go to LO.
  - LO: the accepted byte is the LSB. mem[wr_addr] <= {hi,byte}; wr_addr++ and count++ in the same cycle.
    - If count+1==N, go to DONE.
    - Otherwise return to HI.
  - DONE: for exactly one cycle, load_done=1, table_valid<=1, words_loaded<=N. Then go to IDLE.
- Word format: big-endian, first data byte is bits [15:8].
- Read port:
  - rd_data <= mem[rd_addr] every cycle, independent of state; latency is exactly 1 cycle.
  - Read-during-write to the same address returns the old word (read-first).
- Restart:
  - load_start in LEN/HI/LO aborts the load, goes to LEN, clears counters, and keeps table_valid=0.
  - A byte handshake in the same cycle is discarded.
  - Words already written stay in RAM but are not considered valid.
- load_start in DONE: DONE still completes (load_done pulses), then the FSM enters LEN directly. table_valid is cleared on that transition.
- Bytes offered while in IDLE/DONE are not accepted: byte_ready=0, and the producer holds them.
- wr_addr never wraps, because N<=128. With N=128 the last write goes to address 127.
- table_valid stays 1 across IDLE until the next load_start.
- No combinational path from any input to byte_ready, table_valid or load_done.

Decomposition:
- Shared package (music_pkg):
  - NOTE_ADDR_W=7, NOTE_DATA_W=16, NOTE_DEPTH=128.
  - State enum: IDLE, LEN, HI, LO, DONE.
- One sub-module, note_ram_1r1w: single-clock 128x16 RAM with a registered read port, read-first behaviour and no reset, so it infers block RAM.
- The FSM, byte assembly and counters stay in note_table_loader.

Test Plan:
- Basic load: reset, load_start, then stream 0x02,0x12,0x34,0xAB,0xCD with byte_valid held high.
  - load_done pulses once, table_valid=1, words_loaded=2.
  - rd_addr=0 gives rd_data=0x1234 one cycle later; rd_addr=1 gives 0xABCD.
- Full table: N byte=0x00, then 256 bytes with word k = {k,~k}.
  - words_loaded=128, table_valid=1.
  - rd_addr=127 gives 0x7F80.
  - A further byte is not accepted (byte_ready=0).
- Backpressure and gaps: random byte_valid gaps during the basic load.
  - Identical RAM contents; no byte accepted while byte_ready=0.
- Abort: load_start, N=3, one full word, then load_start mid-HI while that byte is valid, then a fresh N=1 load of 0x5555.
  - table_valid stays 0 until the second DONE; words_loaded=1; address 0 reads 0x5555.
- Reset mid-load: assert sys_rst_n low during LO.
  - All outputs return to reset values asynchronously; table_valid=0; a new load completes normally.
- Read-during-write: rd_addr=0 held while the LO byte for address 0 is accepted.
  - rd_data shows the old word the next cycle and the new word the cycle after.
